if_id_hazard: RTL and testbench



---
 rtl/if_id_hazard.sv | 96 +++++++++
 tb/tb_if_id_hazard.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/if_id_hazard.sv
// IF/ID stage buffer with load-use stall detection and branch flush for the 5-stage pipeline.
// Latency: fetch to ID in 1 cycle; stall, pc_write and gated control are combinational.
// Backpressure: a load-use hazard holds this buffer, drops PC write and sends a bubble to ID/EX.
module if_id_hazard (
    input  logic        clk_BF0,
    input  logic        rst_BF0,
    input  logic [31:0] inst_BF0_IN,
    input  logic [7:0]  nextInst_BF0_IN,
    input  logic [2:0]  M_BF0_IN,
    input  logic [2:0]  EX_BF0_IN,
    input  logic [1:0]  WB_BF0_IN,
    input  logic        idex_memread_IN,
    input  logic [4:0]  idex_rt_IN,
    input  logic        branch_taken_IN,
    output logic [31:0] inst_BF0,
    output logic [7:0]  nextInst_BF0,
    output logic        valid_BF0,
    output logic [2:0]  M_BF0,
    output logic [2:0]  EX_BF0,
    output logic [1:0]  WB_BF0,
    output logic        pc_write,
    output logic        stall,
    output logic [1:0]  state_BF0,
    output logic [15:0] bubble_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] inst_d;
    logic [7:0]  next_inst_d;
    logic        valid_d;
    logic [15:0] bubble_cnt_d;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        pass_ctrl;

    assign rs = inst_BF0[25:21];
    assign rt = inst_BF0[20:16];

    // $zero is never a real producer, so a load targeting it cannot create a hazard.
    assign stall = valid_BF0 & idex_memread_IN & (idex_rt_IN != 5'd0) &
                   ((idex_rt_IN == rs) | (idex_rt_IN == rt));

    assign pc_write  = ~stall | branch_taken_IN;
    assign pass_ctrl = valid_BF0 & ~stall;
    assign M_BF0     = pass_ctrl ? M_BF0_IN  : 3'b000;
    assign EX_BF0    = pass_ctrl ? EX_BF0_IN : 3'b000;
    assign WB_BF0    = pass_ctrl ? WB_BF0_IN : 2'b00;
    assign state_BF0 = state_q;

    always_comb begin
        state_d      = RUN;
        inst_d       = inst_BF0_IN;
        next_inst_d  = nextInst_BF0_IN;
        valid_d      = 1'b1;
        bubble_cnt_d = bubble_cnt;
        // Flush outranks stall: a squashed slot is not counted as a bubble.
        if (branch_taken_IN) begin
            state_d     = FLUSH;
            inst_d      = 32'h0000_0000;
            next_inst_d = 8'h00;
            valid_d     = 1'b0;
        end else if (stall) begin
            state_d     = STALL;
            inst_d      = inst_BF0;
            next_inst_d = nextInst_BF0;
            valid_d     = valid_BF0;
            if (bubble_cnt != 16'hFFFF) begin
                bubble_cnt_d = bubble_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_BF0) begin
        if (rst_BF0) begin
            state_q      <= RUN;
            inst_BF0     <= 32'h0000_0000;
            nextInst_BF0 <= 8'h00;
            valid_BF0    <= 1'b0;
            bubble_cnt   <= 16'h0000;
        end else begin
            state_q      <= state_d;
            inst_BF0     <= inst_d;
            nextInst_BF0 <= next_inst_d;
            valid_BF0    <= valid_d;
            bubble_cnt   <= bubble_cnt_d;
        end
    end

endmodule

// File: tb/tb_if_id_hazard.sv
// Bench for if_id_hazard: reference model predicts registered state into a scoreboard queue.
module tb_if_id_hazard;

    logic        clk_BF0 = 1'b0;
    logic        rst_BF0;
    logic [31:0] inst_BF0_IN;
    logic [7:0]  nextInst_BF0_IN;
    logic [2:0]  M_BF0_IN;
    logic [2:0]  EX_BF0_IN;
    logic [1:0]  WB_BF0_IN;
    logic        idex_memread_IN;
    logic [4:0]  idex_rt_IN;
    logic        branch_taken_IN;
    logic [31:0] inst_BF0;
    logic [7:0]  nextInst_BF0;
    logic        valid_BF0;
    logic [2:0]  M_BF0;
    logic [2:0]  EX_BF0;
    logic [1:0]  WB_BF0;
    logic        pc_write;
    logic        stall;
    logic [1:0]  state_BF0;
    logic [15:0] bubble_cnt;

    if_id_hazard dut (
        .clk_BF0         (clk_BF0),
        .rst_BF0         (rst_BF0),
        .inst_BF0_IN     (inst_BF0_IN),
        .nextInst_BF0_IN (nextInst_BF0_IN),
        .M_BF0_IN        (M_BF0_IN),
        .EX_BF0_IN       (EX_BF0_IN),
        .WB_BF0_IN       (WB_BF0_IN),
        .idex_memread_IN (idex_memread_IN),
        .idex_rt_IN      (idex_rt_IN),
        .branch_taken_IN (branch_taken_IN),
        .inst_BF0        (inst_BF0),
        .nextInst_BF0    (nextInst_BF0),
        .valid_BF0       (valid_BF0),
        .M_BF0           (M_BF0),
        .EX_BF0          (EX_BF0),
        .WB_BF0          (WB_BF0),
        .pc_write        (pc_write),
        .stall           (stall),
        .state_BF0       (state_BF0),
        .bubble_cnt      (bubble_cnt)
    );

    always #5 clk_BF0 = ~clk_BF0;

    typedef struct {
        logic [31:0] inst;
        logic [7:0]  nxt;
        logic        valid;
        logic [1:0]  st;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    // Reference model of the registered state
    logic [31:0] m_inst  = '0;
    logic [7:0]  m_nxt   = '0;
    logic        m_valid = 1'b0;
    logic [1:0]  m_st    = 2'd0;
    logic [15:0] m_cnt   = '0;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic step(input logic rst, input logic [31:0] inst, input logic [7:0] nxt,
                        input logic mr, input logic [4:0] irt, input logic br,
                        input logic chk_comb);
        logic [4:0] rs;
        logic [4:0] rt;
        logic       e_stall;
        logic       pass;
        exp_t       e;
        exp_t       got;
        @(negedge clk_BF0);
        rst_BF0         = rst;
        inst_BF0_IN     = inst;
        nextInst_BF0_IN = nxt;
        M_BF0_IN        = 3'($urandom);
        EX_BF0_IN       = 3'($urandom);
        WB_BF0_IN       = 2'($urandom);
        idex_memread_IN = mr;
        idex_rt_IN      = irt;
        branch_taken_IN = br;
        #1;
        rs      = m_inst[25:21];
        rt      = m_inst[20:16];
        e_stall = m_valid && mr && (irt != 5'd0) && ((irt == rs) || (irt == rt));
        pass    = m_valid && !e_stall;
        if (chk_comb) begin
            chk("stall",    32'(stall),    32'(e_stall));
            chk("pc_write", 32'(pc_write), 32'(!e_stall || br));
            chk("M",        32'(M_BF0),    pass ? 32'(M_BF0_IN)  : 32'd0);
            chk("EX",       32'(EX_BF0),   pass ? 32'(EX_BF0_IN) : 32'd0);
            chk("WB",       32'(WB_BF0),   pass ? 32'(WB_BF0_IN) : 32'd0);
        end
        if (rst) begin
            m_inst = '0; m_nxt = '0; m_valid = 1'b0; m_st = 2'd0; m_cnt = '0;
        end else if (br) begin
            m_inst = '0; m_nxt = '0; m_valid = 1'b0; m_st = 2'd2;
        end else if (e_stall) begin
            m_st = 2'd1;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end else begin
            m_inst = inst; m_nxt = nxt; m_valid = 1'b1; m_st = 2'd0;
        end
        e.inst = m_inst; e.nxt = m_nxt; e.valid = m_valid; e.st = m_st; e.cnt = m_cnt;
        sb_q.push_back(e);
        @(posedge clk_BF0);
        #1;
        got = sb_q.pop_front();
        chk("inst",  inst_BF0,             got.inst);
        chk("next",  32'(nextInst_BF0),    32'(got.nxt));
        chk("valid", 32'(valid_BF0),       32'(got.valid));
        chk("state", 32'(state_BF0),       32'(got.st));
        chk("bcnt",  32'(bubble_cnt),      32'(got.cnt));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_BF0 = 1'b1; inst_BF0_IN = '0; nextInst_BF0_IN = '0;
        M_BF0_IN = '0; EX_BF0_IN = '0; WB_BF0_IN = '0;
        idex_memread_IN = 1'b0; idex_rt_IN = '0; branch_taken_IN = 1'b0;

        // Reset with random inputs (first cycle: DUT state not yet defined)
        step(1'b1, $urandom, 8'($urandom), 1'($urandom), 5'($urandom), 1'($urandom), 1'b0);
        step(1'b1, $urandom, 8'($urandom), 1'($urandom), 5'($urandom), 1'($urandom), 1'b1);
        chk("rst_pc_write", 32'(pc_write), 32'd1);

        // Straight-line load, then load-use on rs
        step(1'b0, 32'h0109_5020, 8'h04, 1'b0, 5'd0, 1'b0, 1'b1);
        step(1'b0, 32'h012A_5822, 8'h08, 1'b1, 5'd8, 1'b0, 1'b1);
        chk("hold_inst", inst_BF0, 32'h0109_5020);
        step(1'b0, 32'h012A_5822, 8'h08, 1'b0, 5'd8, 1'b0, 1'b1);
        chk("reload", inst_BF0, 32'h012A_5822);

        // Load-use on rt (inst 0x012A5822: rs=9, rt=10)
        step(1'b0, 32'h0109_5020, 8'h0C, 1'b1, 5'd10, 1'b0, 1'b1);
        step(1'b0, 32'h0109_5020, 8'h0C, 1'b0, 5'd10, 1'b0, 1'b1);

        // Register $zero: load inst with rs=rt=0, then MemRead with idex_rt=0
        step(1'b0, 32'h0000_4020, 8'h10, 1'b0, 5'd0, 1'b0, 1'b1);
        step(1'b0, 32'h0109_5020, 8'h14, 1'b1, 5'd0, 1'b0, 1'b1);
        chk("zero_nostall_cnt", 32'(bubble_cnt), 32'd2);

        // Branch together with a stall condition
        step(1'b0, 32'h0109_5020, 8'h18, 1'b1, 5'd8, 1'b1, 1'b1);
        step(1'b0, 32'h0109_5020, 8'h1C, 1'b1, 5'd8, 1'b0, 1'b1);

        // Saturation: 65537 consecutive stalls on a held instruction (rs=8)
        step(1'b0, 32'h0109_5020, 8'h20, 1'b1, 5'd8, 1'b0, 1'b1);
        for (int i = 0; i < 65537; i++) begin
            step(1'b0, 32'h8D0B_0000, 8'h24, 1'b1, 5'd8, 1'b0, 1'b1);
        end
        chk("sat", 32'(bubble_cnt), 32'hFFFF);

        // Reset while a stall is pending overrides it
        step(1'b1, 32'h8D0B_0000, 8'h24, 1'b1, 5'd8, 1'b0, 1'b1);
        step(1'b0, 32'hDEAD_BEEF, 8'h28, 1'b0, 5'd0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
